alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side initiator that drives the combinational ArithmeticUnit in the 8-bit CPU.
- Fetches instruction bytes from instruction memory over a req/ack handshake and decodes the MD field.
- Holds the 8x8 register file, presents opcode and operands to the ALU, and writes the ALU result back.
- Sits between instruction memory and ArithmeticUnit; owns the PC and the halt and illegal status.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- NUM_REGS, 8, register count; fixed at 8 because register fields are 3 bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  8  fetch address (PC).
- imem_req  output  1  fetch request.
- imem_ack  input  1  memory ack; imem_data is valid in the same cycle.
- imem_data  input  8  instruction or immediate byte.
- alu_opcode  output  3  opcode to ArithmeticUnit.
- alu_operand_a  output  8  r0.
- alu_operand_b  output  8  r1.
- alu_result  input  8  ArithmeticUnit result (combinational).
- halted  output  1  high in HALT state.
- illegal  output  1  sticky flag for an illegal encoding.
- r0_out  output  8  debug view of r0.

Behaviour:
- Reset (async, rst_n=0):
  - State=FETCH, PC=RESET_PC, all registers=0, IR=0.
  - imem_req=0, halted=0, illegal=0, alu_opcode=3'b000.
  - A reset mid-operation abandons any outstanding fetch; a late imem_ack is ignored.
- Encoding: IR[7:6]=MD.
  - MD=00 LDI: 00 000 ddd, then an immediate byte. rd = imm.
  - MD=01 ALU: 01 000 ooo. r0 = r0 op r1. ooo=100 is ADD; ooo=101 is SUB.
  - MD=10 MOV: 10 ddd sss. rd = rs. ddd==sss is a legal no-op.
  - MD=11 HALT.
  - Illegal: IR[5:3]!=000 for MD=00 or MD=01; MD=01 with ooo not in {100,101}.
    - Sets illegal=1 (sticky until reset).
    - Executes as a no-op; PC continues.
- Fetch handshake:
  - In FETCH or IMM: imem_req=1, imem_addr=PC, both stable until imem_ack=1 is sampled.
  - On the ack cycle: latch imem_data, PC<=PC+1 (8-bit wrap, 8'hFF->8'h00).
  - imem_req drops in the cycle after ack.
  - imem_ack while imem_req=0 is ignored.
- State machine:
  - FETCH -(ack)-> DECODE.
  - DECODE:
    - LDI -> IMM.
    - ALU (legal) -> EXEC.
    - MOV -> FETCH, with the write performed in DECODE.
    - HALT -> HALT.
    - Illegal -> FETCH.
  - IMM -(ack)-> FETCH, writing rd with imem_data on the ack cycle.
  - EXEC -> FETCH.
    - alu_opcode=IR[2:0] is driven during EXEC.
    - r0 <= alu_result at the end of the EXEC cycle.
    - Outside EXEC, alu_opcode=3'b000, so the ALU outputs 0.
  - HALT: terminal. imem_req=0, halted=1. Left only by reset.
- Latency with 0-wait memory (ack in the first req cycle):
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
  - MOV and illegal: 2 cycles.
  - LDI: 3 cycles.
- Arithmetic: 8-bit modulo, performed in ArithmeticUnit. The sequencer does no arithmetic except the PC increment.
- alu_operand_a and alu_operand_b always reflect the current r0 and r1.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (1) and flag_c (1), both reset to 0, updated only at the end of EXEC.
  - flag_z = (alu_result==0).
  - flag_c = bit 8 of the 9-bit r0+r1 for ADD; borrow (r0<r1) for SUB.
- Undefined: ports are absent and there is no flag logic.

Decomposition:
- Package cpu_pkg:
  - mode_e: MD_LDI=2'b00, MD_ALU=2'b01, MD_MOV=2'b10, MD_HALT=2'b11.
  - Constants OP_ADD=3'b100, OP_SUB=3'b101.
  - state_e: FETCH, DECODE, IMM, EXEC, HALT.
  - Widths: DATA_W=8, REG_SEL_W=3.
- Sub-module register_file:
  - 8x8, two asynchronous read ports, one synchronous write port.
  - Async active-low reset clears all registers.

Test Plan:
1. Reset then 0-wait program 00000000,8'h05 / 00000001,8'h03 / 01000100 / 11000000 -> r0_out=8'h08 after EXEC; halted=1; imem_req=0 thereafter.
2. Same program with SUB (01000101), r0=8'h03, r1=8'h05 -> r0_out=8'hFE; with ALU_FLAGS_EN: flag_c=1, flag_z=0.
3. Random 0-3 cycle ack delays -> imem_addr and imem_req stable while waiting; identical final register state to the 0-wait run; PC advances once per ack.
4. Illegal bytes 01000110 and 00101000 -> illegal=1 sticky, registers unchanged, next instruction fetched at PC+1.
5. RESET_PC=8'hFF, first byte MOV 10010000 -> second fetch at imem_addr=8'h00 (wrap); r2=r0.
6. rst_n=0 asserted while imem_req=1 in IMM, ack arriving after reset release -> state FETCH, PC=RESET_PC, all registers 0, late ack ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU control path.
package cpu_pkg;
  localparam int DATA_W    = 8;
  localparam int REG_SEL_W = 3;

  typedef enum logic [1:0] {
    MD_LDI  = 2'b00,
    MD_ALU  = 2'b01,
    MD_MOV  = 2'b10,
    MD_HALT = 2'b11
  } mode_e;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [2:0] {FETCH, DECODE, IMM, EXEC, HALT} state_e;

  // Reserved field bits or an unsupported ALU op make the encoding illegal.
  function automatic logic is_illegal(input logic [DATA_W-1:0] ir);
    logic bad;
    bad = 1'b0;
    case (mode_e'(ir[7:6]))
      MD_LDI:  bad = (ir[5:3] != 3'b000);
      MD_ALU:  bad = (ir[5:3] != 3'b000) || !((ir[2:0] == OP_ADD) || (ir[2:0] == OP_SUB));
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
endpackage

// File: rtl/register_file.sv
// 8x8 register file: two async read ports, one sync write port, plus an r0 tap.
module register_file
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [REG_SEL_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_SEL_W-1:0] i_raddr_a,
  input  logic [REG_SEL_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b,
  output logic [DATA_W-1:0]    o_r0
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_regs <= '0;
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  assign o_r0      = r_regs[0];
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving the combinational ArithmeticUnit.
// Optional ALU_FLAGS_EN adds zero/carry flag outputs updated at the end of EXEC.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_operand_a,
  output logic [7:0] alu_operand_b,
  input  logic [7:0] alu_result,
  output logic       halted,
  output logic       illegal,
`ifdef ALU_FLAGS_EN
  output logic       flag_z,
  output logic       flag_c,
`endif
  output logic       [7:0] r0_out
);
  state_e      r_state;
  logic [7:0]  r_pc, r_ir;
  logic        r_req, r_halted, r_illegal;
  logic [2:0]  r_opcode;

  mode_e       w_md;
  logic        w_ack, w_we;
  logic [2:0]  w_waddr;
  logic [7:0]  w_wdata, w_rs, w_r0, w_r1;

  assign w_md  = mode_e'(r_ir[7:6]);
  assign w_ack = r_req & imem_ack;

  register_file #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
    .i_raddr_a(r_ir[2:0]), .i_raddr_b(3'd1),
    .o_rdata_a(w_rs), .o_rdata_b(w_r1), .o_r0(w_r0)
  );

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ir[2:0];
    w_wdata = imem_data;
    case (r_state)
      DECODE: if (w_md == MD_MOV) begin
        w_we    = 1'b1;
        w_waddr = r_ir[5:3];
        w_wdata = w_rs;
      end
      IMM:  w_we = w_ack;
      EXEC: begin
        w_we    = 1'b1;
        w_waddr = 3'd0;
        w_wdata = alu_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_req     <= 1'b0;
      r_opcode  <= 3'b000;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        // req comes up one cycle after reset, so a stale ack is never taken
        FETCH: if (w_ack) begin
          r_ir    <= imem_data;
          r_pc    <= r_pc + 8'd1;
          r_req   <= 1'b0;
          r_state <= DECODE;
        end else r_req <= 1'b1;
        DECODE: begin
          if (w_md == MD_HALT) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (is_illegal(r_ir)) begin
            r_illegal <= 1'b1;
            r_req     <= 1'b1;
            r_state   <= FETCH;
          end else if (w_md == MD_LDI) begin
            r_req   <= 1'b1;
            r_state <= IMM;
          end else if (w_md == MD_ALU) begin
            r_opcode <= r_ir[2:0];
            r_state  <= EXEC;
          end else begin
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        // req stays high: the next instruction fetch follows immediately
        IMM: if (w_ack) begin
          r_pc    <= r_pc + 8'd1;
          r_state <= FETCH;
        end
        EXEC: begin
          r_opcode <= 3'b000;
          r_req    <= 1'b1;
          r_state  <= FETCH;
        end
        HALT:    r_req <= 1'b0;
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic       r_fz, r_fc;
  logic [8:0] w_sum;
  assign w_sum = {1'b0, w_r0} + {1'b0, w_r1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fz <= 1'b0;
      r_fc <= 1'b0;
    end else if (r_state == EXEC) begin
      r_fz <= (alu_result == 8'h00);
      r_fc <= (r_ir[2:0] == OP_ADD) ? w_sum[8] : (w_r0 < w_r1);
    end
  end

  assign flag_z = r_fz;
  assign flag_c = r_fc;
`endif

  assign imem_addr     = r_pc;
  assign imem_req      = r_req;
  assign alu_opcode    = r_opcode;
  assign alu_operand_a = w_r0;
  assign alu_operand_b = w_r1;
  assign halted        = r_halted;
  assign illegal       = r_illegal;
  assign r0_out        = w_r0;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer against an instruction-level model.
module tb_alu_sequencer;
  localparam logic [7:0] RPC = 8'hFF;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] imem_addr, imem_data, alu_operand_a, alu_operand_b, alu_result, r0_out;
  logic       imem_req, imem_ack, halted, illegal;
  logic [2:0] alu_opcode;
`ifdef ALU_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  alu_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .halted(halted), .illegal(illegal),
`ifdef ALU_FLAGS_EN
    .flag_z(flag_z), .flag_c(flag_c),
`endif
    .r0_out(r0_out)
  );

  always #5 clk = ~clk;

  // ArithmeticUnit stand-in
  always_comb begin
    alu_result = 8'h00;
    if (alu_opcode == 3'b100)      alu_result = alu_operand_a + alu_operand_b;
    else if (alu_opcode == 3'b101) alu_result = alu_operand_a - alu_operand_b;
  end

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [256];
  logic [7:0] prog [$];
  int         max_dly = 0, n_ack = 0;
  bit         hold = 1'b1, manual = 1'b0;

  // Memory responder: random ack delay, checks req/addr hold while waiting
  initial begin
    int         wait_cnt;
    logic [7:0] held_addr;
    wait_cnt = -1; held_addr = '0;
    imem_ack = 1'b0; imem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (manual) continue;
      imem_ack = 1'b0;
      if (!rst_n || hold) begin wait_cnt = -1; continue; end
      if (wait_cnt >= 0) begin
        check("req_hold", 32'(imem_req), 32'd1);
        check("addr_hold", 32'(imem_addr), 32'(held_addr));
      end
      if (!imem_req) wait_cnt = -1;
      else begin
        if (wait_cnt < 0) begin
          wait_cnt  = int'($urandom_range(max_dly, 0));
          held_addr = imem_addr;
        end
        if (wait_cnt == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          n_ack++;
          wait_cnt  = -1;
        end else wait_cnt--;
      end
    end
  end

  // Instruction-level reference model
  logic [7:0] m_regs [8];
  logic [7:0] m_pc;
  logic       m_ill, m_z, m_c;
  int         m_fetch;
  task automatic model();
    logic [7:0] b;
    int         s;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pc = RPC; m_ill = 0; m_z = 0; m_c = 0; m_fetch = 0;
    for (s = 0; s < 300; s++) begin
      b = mem[m_pc]; m_pc++; m_fetch++;
      if (b[7:6] == 2'b11) break;
      if (b[7:6] == 2'b00) begin
        if (b[5:3] != 0) m_ill = 1;
        else begin m_regs[b[2:0]] = mem[m_pc]; m_pc++; m_fetch++; end
      end else if (b[7:6] == 2'b01) begin
        if (b[5:3] != 0 || (b[2:0] != 3'd4 && b[2:0] != 3'd5)) m_ill = 1;
        else begin
          int a, c, r;
          a = int'(m_regs[0]); c = int'(m_regs[1]);
          r = (b[2:0] == 3'd4) ? a + c : a - c;
          m_c = (b[2:0] == 3'd4) ? (r > 255) : (a < c);
          m_regs[0] = 8'(r);
          m_z = (m_regs[0] == 8'h00);
        end
      end else m_regs[b[5:3]] = m_regs[b[2:0]];
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    for (int i = 0; i < prog.size(); i++) mem[8'(int'(RPC) + i)] = prog[i];
  endtask

  task automatic gen_prog(input int n);
    logic [7:0] b;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(4, 0))
        0: begin prog.push_back({5'b00000, 3'($urandom_range(7, 0))}); prog.push_back(8'($urandom)); end
        1: prog.push_back($urandom_range(1, 0) ? 8'h44 : 8'h45);
        2: prog.push_back({2'b10, 6'($urandom)});
        3: begin b = 8'($urandom); if (b[7:6] == 2'b11) b[7:6] = 2'b01; prog.push_back(b); end
        default: prog.push_back(8'h45);
      endcase
    end
    prog.push_back({2'b11, 6'($urandom)});
  endtask

  task automatic do_reset();
    hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'(RPC));
    check("rst_r0", 32'(r0_out), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic finish_and_compare(input string name);
    int cyc;
    cyc = 0;
    while (!halted && cyc < 3000) begin @(negedge clk); cyc++; end
    check({name, "_halted"}, 32'(halted), 32'd1);
    repeat (4) @(negedge clk);
    check({name, "_req_off"}, 32'(imem_req), 32'd0);
    check({name, "_fetches"}, 32'(n_ack), 32'(m_fetch));
    check({name, "_pc"}, 32'(imem_addr), 32'(m_pc));
    check({name, "_illegal"}, 32'(illegal), 32'(m_ill));
    check({name, "_r0_out"}, 32'(r0_out), 32'(m_regs[0]));
    check({name, "_opb"}, 32'(alu_operand_b), 32'(m_regs[1]));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", name, i), 32'(dut.u_rf.r_regs[i]), 32'(m_regs[i]));
`ifdef ALU_FLAGS_EN
    check({name, "_flag_z"}, 32'(flag_z), 32'(m_z));
    check({name, "_flag_c"}, 32'(flag_c), 32'(m_c));
`endif
    hold = 1'b1;
  endtask

  task automatic run_prog(input string name, input int dly);
    load_prog();
    model();
    max_dly = dly;
    do_reset();
    n_ack = 0;
    hold  = 1'b0;
    finish_and_compare(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    // ADD 5+3, then the same program with SUB 3-5
    prog = {8'h00, 8'h05, 8'h01, 8'h03, 8'h44, 8'hC0};
    run_prog("t1", 0);
    check("t1_sum", 32'(r0_out), 32'h08);
    prog = {8'h00, 8'h03, 8'h01, 8'h05, 8'h45, 8'hC0};
    run_prog("t2", 0);
    check("t2_diff", 32'(r0_out), 32'hFE);
`ifdef ALU_FLAGS_EN
    check("t2_c", 32'(flag_c), 32'd1);
    check("t2_z", 32'(flag_z), 32'd0);
`endif
    run_prog("t2d", 3);
    check("t2d_diff", 32'(r0_out), 32'hFE);

    // illegal encodings are sticky no-ops; MOV at RESET_PC=FF wraps fetch to 00
    prog = {8'h00, 8'h11, 8'h46, 8'h28, 8'h90, 8'hC0};
    run_prog("t4", 2);
    check("t4_illegal", 32'(illegal), 32'd1);
    check("t4_r2", 32'(dut.u_rf.r_regs[2]), 32'h11);
    prog = {8'h00, 8'h5A, 8'h90, 8'hC0};
    run_prog("t5", 0);

    for (int k = 0; k < 6; k++) begin
      gen_prog(int'($urandom_range(16, 4)));
      run_prog($sformatf("rnd%0d_w0", k), 0);
      run_prog($sformatf("rnd%0d_w3", k), 3);
    end

    // reset while waiting in IMM; late ack right after release is ignored
    prog = {8'h02, 8'h77, 8'h44, 8'hC0};
    load_prog(); model(); max_dly = 0;
    do_reset();
    n_ack = 0; hold = 1'b0;
    cyc = 0;
    while (n_ack < 1 && cyc < 50) begin @(negedge clk); cyc++; end
    hold = 1'b1;
    cyc = 0;
    while (!(imem_req && imem_addr == 8'h00) && cyc < 20) begin @(negedge clk); cyc++; end
    check("t6_in_imm", {imem_req, imem_addr}, {1'b1, 8'h00});
    manual = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_pc", 32'(imem_addr), 32'(RPC));
    rst_n = 1'b1; imem_ack = 1'b1; imem_data = 8'h77;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t6_late_pc", 32'(imem_addr), 32'(RPC));
    check("t6_late_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("t6_r%0d_zero", i), 32'(dut.u_rf.r_regs[i]), 32'd0);
    manual = 1'b0; n_ack = 0; hold = 1'b0;
    finish_and_compare("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
